atm_ctrl_fsm: RTL

Parametrised ATM session controller, the successor to the fixed 5-bit-PIN / 8-bit-amount ATM FSM. It sequences one card session through card insert, PIN entry, amount entry and cash dispense to card eject. It adds a retry counter with lockout, a tracked account balance with insufficient-funds rejection, cancel handling and an optional daily withdrawal limit. It sits between the keypad/card-reader front end and the dispenser actuator.

---
 rtl/atm_pkg.sv | 15 +
 rtl/atm_pin_check.sv | 48 ++++
 rtl/atm_ctrl_fsm.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared state encoding for the ATM session controller.
package atm_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    PIN_ENTRY = 3'd1,
    AMT_ENTRY = 3'd2,
    DISPENSE  = 3'd3,
    EJECT     = 3'd4,
    LOCKED    = 3'd5
  } atm_state_e;

endpackage

// File: rtl/atm_pin_check.sv
// PIN comparator with a saturating wrong-attempt counter and registered error pulse.
module atm_pin_check #(
  parameter int unsigned           PIN_W     = 5,
  parameter logic [PIN_W-1:0]      PIN_CODE  = 5'b11010,
  parameter int unsigned           MAX_TRIES = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             check_i,
  input  logic [PIN_W-1:0] pin_i,
  output logic             match_o,
  output logic             err_pulse_o,
  output logic             lockout_o
);

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  logic [3:0] tries_q, tries_d;
  logic       err_q, err_d;

  assign match_o     = (pin_i == PIN_CODE);
  assign err_pulse_o = err_q;
  // Independent of check_i so the caller can use it while deciding to check.
  assign lockout_o   = !match_o && (tries_q >= MAX_T - 4'd1);

  always_comb begin
    tries_d = tries_q;
    err_d   = 1'b0;
    if (clr_i) begin
      tries_d = '0;
    end else if (check_i && !match_o) begin
      err_d = 1'b1;
      if (tries_q < MAX_T) tries_d = tries_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tries_q <= '0;
      err_q   <= 1'b0;
    end else begin
      tries_q <= tries_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/atm_ctrl_fsm.sv
// ATM session controller: card, PIN, amount, dispense, eject, with lockout.
// Optional daily withdrawal cap enabled by defining ATM_DAILY_LIMIT_EN.
module atm_ctrl_fsm
  import atm_pkg::*;
#(
  parameter int unsigned      PIN_W       = 5,
  parameter logic [PIN_W-1:0] PIN_CODE    = 5'b11010,
  parameter int unsigned      AMT_W       = 8,
  parameter int unsigned      BAL_W       = 16,
  parameter int unsigned      INIT_BAL    = 1000,
  parameter int unsigned      MAX_TRIES   = 3,
  parameter int unsigned      DAILY_LIMIT = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               card_in,
  input  logic [PIN_W-1:0]   pin,
  input  logic               pin_valid,
  input  logic [AMT_W-1:0]   amount,
  input  logic               amt_valid,
  input  logic               cancel,
  input  logic               unlock,
  input  logic               day_clr,
  output logic [STATE_W-1:0] state,
  output logic               pin_err,
  output logic               amt_err,
  output logic               insufficient,
  output logic               limit_err,
  output logic               dispense,
  output logic [AMT_W-1:0]   dispense_amt,
  output logic               card_eject,
  output logic               locked,
  output logic [BAL_W-1:0]   balance
);

  atm_state_e       state_q, state_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             amt_err_q, amt_err_d;
  logic             insuf_q, insuf_d;
  logic             lim_q, lim_d;
  logic             disp_q, eject_q, locked_q;
  logic             pin_clr, pin_chk, pin_match, pin_lockout;
  logic             over_limit;
  logic [BAL_W-1:0] req_ext, amt_ext;

  assign req_ext = BAL_W'(amount);
  assign amt_ext = BAL_W'(amt_q);

  atm_pin_check #(
    .PIN_W    (PIN_W),
    .PIN_CODE (PIN_CODE),
    .MAX_TRIES(MAX_TRIES)
  ) u_pin_check (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clr_i      (pin_clr),
    .check_i    (pin_chk),
    .pin_i      (pin),
    .match_o    (pin_match),
    .err_pulse_o(pin_err),
    .lockout_o  (pin_lockout)
  );

`ifdef ATM_DAILY_LIMIT_EN
  localparam logic [BAL_W:0] LIMIT = (BAL_W+1)'(DAILY_LIMIT);
  logic [BAL_W-1:0] acc_q, acc_d;

  assign over_limit = ({1'b0, acc_q} + {1'b0, req_ext}) > LIMIT;

  // A same-cycle clear and dispense leaves only the new dispense counted.
  always_comb begin
    acc_d = acc_q;
    if (day_clr)                 acc_d = (state_q == DISPENSE) ? amt_ext : '0;
    else if (state_q == DISPENSE) acc_d = acc_q + amt_ext;
  end

  always_ff @(posedge clk) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`else
  logic unused_cfg;
  assign over_limit = 1'b0;
  assign unused_cfg = ^{day_clr, BAL_W'(DAILY_LIMIT)};
`endif

  always_comb begin
    state_d   = state_q;
    bal_d     = bal_q;
    amt_d     = amt_q;
    amt_err_d = 1'b0;
    insuf_d   = 1'b0;
    lim_d     = 1'b0;
    pin_clr   = 1'b0;
    pin_chk   = 1'b0;
    case (state_q)
      IDLE: if (card_in) begin
        state_d = PIN_ENTRY;
        pin_clr = 1'b1;
      end
      PIN_ENTRY: begin
        if (cancel) begin
          state_d = EJECT;
        end else if (pin_valid) begin
          pin_chk = 1'b1;
          if (pin_match)        state_d = AMT_ENTRY;
          else if (pin_lockout) state_d = LOCKED;
        end
      end
      AMT_ENTRY: begin
        if (cancel) begin
          state_d = EJECT;
        end else if (amt_valid) begin
          if (amount == '0)         amt_err_d = 1'b1;
          else if (req_ext > bal_q) insuf_d   = 1'b1;
          else if (over_limit)      lim_d     = 1'b1;
          else begin
            amt_d   = amount;
            state_d = DISPENSE;
          end
        end
      end
      DISPENSE: begin
        bal_d   = bal_q - amt_ext;
        state_d = EJECT;
      end
      EJECT:  state_d = IDLE;
      LOCKED: if (unlock) begin
        state_d = IDLE;
        pin_clr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      bal_q     <= BAL_W'(INIT_BAL);
      amt_q     <= '0;
      amt_err_q <= 1'b0;
      insuf_q   <= 1'b0;
      lim_q     <= 1'b0;
      disp_q    <= 1'b0;
      eject_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bal_q     <= bal_d;
      amt_q     <= amt_d;
      amt_err_q <= amt_err_d;
      insuf_q   <= insuf_d;
      lim_q     <= lim_d;
      disp_q    <= (state_d == DISPENSE);
      eject_q   <= (state_d == EJECT);
      locked_q  <= (state_d == LOCKED);
    end
  end

  assign state        = state_q;
  assign balance      = bal_q;
  assign dispense_amt = amt_q;
  assign amt_err      = amt_err_q;
  assign insufficient = insuf_q;
  assign limit_err    = lim_q;
  assign dispense     = disp_q;
  assign card_eject   = eject_q;
  assign locked       = locked_q;

endmodule
